instr_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the instruction memory and the single-cycle MIPS core.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit words, MSB first.
- Writes each word into instruction memory through a dedicated write port.
- Holds the core in reset until the last word is written, then releases it.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/instr_loader_if.sv | 28 ++
 rtl/byte_packer.sv | 44 ++++
 rtl/instr_loader.sv | 104 ++++++++++
 tb/tb_instr_loader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader: default widths,
// FSM state encoding and the bytes-per-word helper.
package loader_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BYTE_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 100;
  localparam int ADDR_WIDTH_DEF = 7;

  function automatic int bytes_per_word(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH_DEF, BYTE_WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready handshake between a program source (master) and
// the instruction loader (slave).
interface instr_loader_if
  import loader_pkg::*;
#(
  parameter int Byte_Width = BYTE_WIDTH_DEF
);

  logic [Byte_Width-1:0] Byte_In;
  logic                  Byte_Valid;
  logic                  Byte_Last;
  logic                  Byte_Ready;

  modport master (
    output Byte_In,
    output Byte_Valid,
    output Byte_Last,
    input  Byte_Ready
  );

  modport slave (
    input  Byte_In,
    input  Byte_Valid,
    input  Byte_Last,
    output Byte_Ready
  );

endinterface

// File: rtl/byte_packer.sv
// Shift register plus byte counter: packs stream bytes MSB first into one
// word and flags the transfer that completes it.
module byte_packer
  import loader_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int Byte_Width = BYTE_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic [Byte_Width-1:0] i_byte,
  output logic                  o_word_ready,
  output logic [Data_Width-1:0] o_word
);

  localparam int BPW = bytes_per_word(Data_Width, Byte_Width);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]         r_cnt;
  logic [Data_Width-1:0] r_shift;
  logic                  w_last_byte;

  assign w_last_byte = (r_cnt == CW'(BPW - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_shift) begin
      r_shift <= {r_shift[Data_Width-Byte_Width-1:0], i_byte};
      r_cnt   <= w_last_byte ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_word_ready = i_shift && w_last_byte;
  assign o_word       = r_shift;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: packs a byte stream into words, writes them to instruction
// memory and holds the core in reset until the program is fully loaded.
module instr_loader
  import loader_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int Byte_Width = BYTE_WIDTH_DEF,
  parameter int Depth      = DEPTH_DEF,
  parameter int Addr_Width = ADDR_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  instr_loader_if.slave         byte_if,
  output logic                  IM_WE,
  output logic [Addr_Width-1:0] IM_WA,
  output logic [Data_Width-1:0] IM_WD,
  output logic                  CPU_RST,
  output logic                  Done,
  output logic                  Error,
  output logic [Addr_Width-1:0] Word_Count
);

  state_e                r_state;
  logic [Addr_Width-1:0] r_word_count;
  logic                  r_error;
  logic                  r_last;

  logic                  w_xfer;
  logic                  w_clear;
  logic                  w_word_ready;
  logic [Data_Width-1:0] w_word;

  assign w_xfer  = (r_state == ST_LOAD) && byte_if.Byte_Valid;
  assign w_clear = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && Start;

  byte_packer #(
    .Data_Width (Data_Width),
    .Byte_Width (Byte_Width)
  ) u_packer (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_clear      (w_clear),
    .i_shift      (w_xfer),
    .i_byte       (byte_if.Byte_In),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_word_count <= '0;
      r_error      <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            r_state      <= ST_LOAD;
            r_word_count <= '0;
            r_error      <= 1'b0;
            r_last       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_last <= byte_if.Byte_Last;
            if (w_word_ready) begin
              r_state <= ST_WRITE;
            end else if (byte_if.Byte_Last) begin
              // Program ended mid-word: drop the partial word.
              r_state <= ST_DONE;
              r_error <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_word_count <= r_word_count + 1'b1;
          if (r_last) begin
            r_state <= ST_DONE;
          end else if (r_word_count == Addr_Width'(Depth - 1)) begin
            r_state <= ST_DONE;
            r_error <= 1'b1;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs come straight from registers or the state register.
  assign byte_if.Byte_Ready = (r_state == ST_LOAD);
  assign IM_WE              = (r_state == ST_WRITE);
  assign IM_WA              = r_word_count;
  assign IM_WD              = w_word;
  assign CPU_RST            = (r_state != ST_DONE);
  assign Done               = (r_state == ST_DONE);
  assign Error              = r_error;
  assign Word_Count         = r_word_count;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized byte streams compared
// every cycle against a queue-based reference model, plus pinned literals.
module tb_instr_loader;
  import loader_pkg::*;

  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int DEPTH = 100;
  localparam int AW    = 7;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Start;
  logic          IM_WE;
  logic [AW-1:0] IM_WA;
  logic [DW-1:0] IM_WD;
  logic          CPU_RST;
  logic          Done;
  logic          Error;
  logic [AW-1:0] Word_Count;

  always #5 CLK = ~CLK;

  instr_loader_if #(.Byte_Width(BW)) bif ();

  instr_loader #(
    .Data_Width (DW),
    .Byte_Width (BW),
    .Depth      (DEPTH),
    .Addr_Width (AW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start      (Start),
    .byte_if    (bif),
    .IM_WE      (IM_WE),
    .IM_WA      (IM_WA),
    .IM_WD      (IM_WD),
    .CPU_RST    (CPU_RST),
    .Done       (Done),
    .Error      (Error),
    .Word_Count (Word_Count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a loader is "active" from Start until it finishes, bytes
  // collect in a queue, and a full queue becomes one pending write cycle.
  bit         m_active, m_write, m_done, m_err, m_last;
  int         m_words;
  logic [31:0] m_wd;
  logic [7:0] m_q[$];

  function automatic void model_reset();
    m_active = 0; m_write = 0; m_done = 0; m_err = 0; m_last = 0;
    m_words  = 0; m_wd = '0;
    m_q.delete();
  endfunction

  function automatic void model_step(input bit rst, input bit start, input bit valid,
                                     input logic [7:0] b, input bit last);
    if (rst) begin
      model_reset();
    end else if (m_write) begin
      m_write = 0;
      m_words++;
      if (m_last) begin
        m_active = 0; m_done = 1;
      end else if (m_words == DEPTH) begin
        m_active = 0; m_done = 1; m_err = 1;
      end
    end else if (m_active) begin
      if (valid) begin
        m_q.push_back(b);
        if (m_q.size() == 4) begin
          m_wd    = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_q.delete();
          m_write = 1;
          m_last  = last;
        end else if (last) begin
          m_active = 0; m_done = 1; m_err = 1;
        end
      end
    end else if (start) begin
      m_active = 1; m_done = 0; m_err = 0; m_words = 0;
      m_q.delete();
    end
  endfunction

  // Per-cycle compare, plus a record of what the DUT actually wrote.
  bit          cmp_en = 0;
  bit          prev_we = 0;
  logic [31:0] dut_mem [0:127];
  int          dut_writes = 0;

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("byte_ready", 32'(bif.Byte_Ready), 32'(m_active && !m_write));
      check("im_we", 32'(IM_WE), 32'(m_write));
      if (m_write) begin
        check("im_wa", 32'(IM_WA), 32'(m_words));
        check("im_wd", IM_WD, m_wd);
      end
      check("cpu_rst", 32'(CPU_RST), 32'(!m_done));
      check("done", 32'(Done), 32'(m_done));
      check("error", 32'(Error), 32'(m_err));
      check("word_count", 32'(Word_Count), 32'(m_words));
      check("we_back_to_back", 32'(IM_WE && prev_we), 32'd0);
      prev_we = IM_WE;
      if (IM_WE) begin
        dut_mem[IM_WA] = IM_WD;
        dut_writes++;
      end
    end
  end

  task automatic drive_cycle(input bit rst, input bit start, input bit valid,
                             input logic [7:0] b, input bit last);
    RST            = rst;
    Start          = start;
    bif.Byte_Valid = valid;
    bif.Byte_In    = b;
    bif.Byte_Last  = last;
    @(posedge CLK);
    model_step(rst, start, valid, b, last);
    @(negedge CLK);
  endtask

  logic [7:0] stim[$];

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid
  // with stray Start pulses (which the loader must ignore while busy).
  task automatic send_stream(input bit last_on_end, input int mode, input int extra);
    int idx;
    int cyc;
    int budget;
    bit v;
    bit rdy;
    bit lst;
    bit st;
    idx    = 0;
    cyc    = 0;
    budget = stim.size() * 4 + 50;
    while (idx < stim.size() && cyc < budget && !m_done) begin
      v   = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      st  = (mode == 2) ? ($urandom_range(0, 9) == 0) : 1'b0;
      rdy = m_active && !m_write;
      lst = last_on_end && (idx == stim.size() - 1);
      drive_cycle(0, st, v, stim[idx], lst);
      if (v && rdy) idx++;
      cyc++;
    end
    while (!m_done && cyc < budget) begin
      drive_cycle(0, 0, 0, 8'h00, 0);
      cyc++;
    end
    check("stream_reached_done", 32'(Done), 32'd1);
    for (int i = 0; i < extra; i++) begin
      drive_cycle(0, 0, 1, 8'($urandom), 0);
    end
  endtask

  task automatic start_load();
    dut_writes = 0;
    for (int i = 0; i < 128; i++) dut_mem[i] = 'x;
    drive_cycle(0, 1, 0, 8'h00, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w99;
    int          len;
    RST = 1; Start = 0;
    bif.Byte_Valid = 0; bif.Byte_In = '0; bif.Byte_Last = 0;
    model_reset();
    cmp_en = 1;
    drive_cycle(1, 0, 0, 8'h00, 0);
    drive_cycle(1, 0, 0, 8'h00, 0);
    check("reset_cpu_rst", 32'(CPU_RST), 32'd1);
    check("reset_word_count", 32'(Word_Count), 32'd0);
    check("reset_im_wd", IM_WD, 32'd0);
    drive_cycle(0, 0, 1, 8'h55, 1);
    check("idle_ignores_bytes", 32'(Word_Count + Done), 32'd0);

    // Two-word program, continuous valid.
    start_load();
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    send_stream(1, 0, 0);
    check("t1_word0", dut_mem[0], 32'h20080005);
    check("t1_word1", dut_mem[1], 32'hAC080000);
    check("t1_writes", 32'(dut_writes), 32'd2);
    check("t1_word_count", 32'(Word_Count), 32'd2);
    check("t1_cpu_rst", 32'(CPU_RST), 32'd0);
    check("t1_error", 32'(Error), 32'd0);

    // Same program with Byte_Valid toggling.
    start_load();
    send_stream(1, 1, 0);
    check("t2_word0", dut_mem[0], 32'h20080005);
    check("t2_word1", dut_mem[1], 32'hAC080000);
    check("t2_writes", 32'(dut_writes), 32'd2);

    // Program ends mid-word.
    start_load();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_stream(1, 0, 0);
    check("t3_word0", dut_mem[0], 32'h01020304);
    check("t3_writes", 32'(dut_writes), 32'd1);
    check("t3_word_count", 32'(Word_Count), 32'd1);
    check("t3_error", 32'(Error), 32'd1);

    // Memory overflow: 400 bytes, no Byte_Last.
    start_load();
    stim.delete();
    for (int i = 0; i < 400; i++) stim.push_back(8'($urandom));
    w99 = {stim[396], stim[397], stim[398], stim[399]};
    send_stream(0, 2, 8);
    check("t4_writes", 32'(dut_writes), 32'd100);
    check("t4_word_count", 32'(Word_Count), 32'd100);
    check("t4_error", 32'(Error), 32'd1);
    check("t4_last_word", dut_mem[99], w99);
    check("t4_ready_low", 32'(bif.Byte_Ready), 32'd0);

    // Reset in the middle of a word.
    start_load();
    drive_cycle(0, 0, 1, 8'hAA, 0);
    drive_cycle(0, 0, 1, 8'hBB, 0);
    drive_cycle(1, 0, 1, 8'hCC, 0);
    check("t5_cpu_rst", 32'(CPU_RST), 32'd1);
    check("t5_ready", 32'(bif.Byte_Ready), 32'd0);
    check("t5_done", 32'(Done), 32'd0);
    start_load();
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(1, 0, 0);
    check("t5_word0", dut_mem[0], 32'h11223344);
    check("t5_error", 32'(Error), 32'd0);

    // Restart from DONE.
    start_load();
    check("t6_cpu_rst", 32'(CPU_RST), 32'd1);
    check("t6_done", 32'(Done), 32'd0);
    stim = '{8'h00, 8'h00, 8'h00, 8'h08};
    send_stream(1, 0, 0);
    check("t6_word0", dut_mem[0], 32'h00000008);
    check("t6_word_count", 32'(Word_Count), 32'd1);

    // Random program lengths and handshake patterns.
    for (int t = 0; t < 8; t++) begin
      start_load();
      len = $urandom_range(1, 40);
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
      send_stream(1, 2, 3);
    end

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
